router_port_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one router input port among `N_REQ` local flit sources (sensor readout channels, test injectors). Grants are held from head flit to tail flit, so packets are never interleaved. The output uses the same valid/ready flit handshake as every router port. A one-entry output register gives one flit per cycle throughput with a registered output.

---
 rtl/router_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/router_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_router_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Flit type codes and helpers shared by the router port logic.
package router_pkg;

    localparam int ROUTER_FLIT_W = 32;
    localparam int FLIT_TYPE_MSB = ROUTER_FLIT_W - 1;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_TAIL   = 2'b01,
        FLIT_HEAD   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    function automatic flit_type_e flit_type(input logic [ROUTER_FLIT_W-1:0] flit);
        return flit_type_e'(flit[FLIT_TYPE_MSB -: 2]);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority pick: first set request at or above ptr, with wrap.
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt
);

    logic [PTR_W:0] idx;
    logic           found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(N_REQ)) begin
                idx = idx - (PTR_W+1)'(N_REQ);
            end
            if (!found && req[idx[PTR_W-1:0]]) begin
                gnt[idx[PTR_W-1:0]] = 1'b1;
                found               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_port_arbiter.sv
// Packet-level round-robin arbiter feeding one router input port through a one-entry output register.
module router_port_arbiter
    import router_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int FLIT_W = ROUTER_FLIT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ*FLIT_W-1:0] req_flit_i,
    input  logic [N_REQ-1:0]        req_vld_i,
    output logic [N_REQ-1:0]        req_rdy_o,
    output logic [FLIT_W-1:0]       out_flit_o,
    output logic                    out_vld_o,
    input  logic                    out_rdy_i,
    output logic [N_REQ-1:0]        grant_o,
    output logic                    proto_err_o,
    output logic [15:0]             pkt_cnt_o
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [FLIT_W-1:0] out_flit_q, out_flit_d;
    logic              out_vld_q, out_vld_d;
    logic              proto_err_q, proto_err_d;
    logic [15:0]       pkt_cnt_q, pkt_cnt_d;

    logic [N_REQ-1:0]  arb_gnt;
    logic [N_REQ-1:0]  sel_oh;
    logic [FLIT_W-1:0] sel_flit;
    logic [PTR_W-1:0]  sel_idx;
    logic [PTR_W-1:0]  ptr_next;
    logic              slot_free;
    logic              accept;
    flit_type_e        ftype;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
        .req (req_vld_i),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt)
    );

    // Once a packet owns the port, only the owner may be selected until its tail.
    assign sel_oh    = (state_q == S_IDLE) ? arb_gnt : grant_q;
    assign slot_free = !out_vld_q || out_rdy_i;
    assign req_rdy_o = (slot_free && !rst) ? sel_oh : '0;
    assign accept    = |(req_vld_i & req_rdy_o);

    always_comb begin
        sel_flit = '0;
        sel_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel_oh[i]) begin
                sel_flit = sel_flit | req_flit_i[i*FLIT_W +: FLIT_W];
                sel_idx  = PTR_W'(i);
            end
        end
    end

    assign ptr_next = (sel_idx == PTR_W'(N_REQ-1)) ? '0 : sel_idx + PTR_W'(1);
    assign ftype    = flit_type_e'(sel_flit[FLIT_W-1 -: 2]);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        out_flit_d  = out_flit_q;
        out_vld_d   = out_vld_q;
        proto_err_d = proto_err_q;
        pkt_cnt_d   = pkt_cnt_q;

        if (accept) begin
            out_flit_d = sel_flit;
            out_vld_d  = 1'b1;
        end else if (out_rdy_i) begin
            out_vld_d = 1'b0;
        end

        if (accept) begin
            case (state_q)
                S_IDLE: begin
                    if (ftype == FLIT_SINGLE || ftype == FLIT_TAIL) begin
                        rr_ptr_d  = ptr_next;
                        pkt_cnt_d = pkt_cnt_q + 16'd1;
                    end else begin
                        state_d = S_BUSY;
                        grant_d = sel_oh;
                    end
                    if (ftype == FLIT_TAIL || ftype == FLIT_BODY) begin
                        proto_err_d = 1'b1;
                    end
                end
                default: begin
                    if (ftype == FLIT_TAIL || ftype == FLIT_SINGLE) begin
                        state_d   = S_IDLE;
                        grant_d   = '0;
                        rr_ptr_d  = ptr_next;
                        pkt_cnt_d = pkt_cnt_q + 16'd1;
                    end
                    // Misplaced heads/singles are still forwarded; only the flag records them.
                    if (ftype == FLIT_HEAD || ftype == FLIT_SINGLE) begin
                        proto_err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            out_flit_q  <= '0;
            out_vld_q   <= 1'b0;
            proto_err_q <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            out_flit_q  <= out_flit_d;
            out_vld_q   <= out_vld_d;
            proto_err_q <= proto_err_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    assign out_flit_o  = out_flit_q;
    assign out_vld_o   = out_vld_q;
    assign grant_o     = grant_q;
    assign proto_err_o = proto_err_q;
    assign pkt_cnt_o   = pkt_cnt_q;

endmodule

// File: tb/tb_router_port_arbiter.sv
// Directed bench for router_port_arbiter: cycle table for round-robin, sequences for lock/stall/error/reset.
module tb_router_port_arbiter;
    import router_pkg::*;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] req_flit_i;
    logic [N-1:0]   req_vld_i;
    logic [N-1:0]   req_rdy_o;
    logic [W-1:0]   out_flit_o;
    logic           out_vld_o;
    logic           out_rdy_i;
    logic [N-1:0]   grant_o;
    logic           proto_err_o;
    logic [15:0]    pkt_cnt_o;

    router_port_arbiter #(.N_REQ(N), .FLIT_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_flit_i  (req_flit_i),
        .req_vld_i   (req_vld_i),
        .req_rdy_o   (req_rdy_o),
        .out_flit_o  (out_flit_o),
        .out_vld_o   (out_vld_o),
        .out_rdy_i   (out_rdy_i),
        .grant_o     (grant_o),
        .proto_err_o (proto_err_o),
        .pkt_cnt_o   (pkt_cnt_o)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic [N-1:0]  vld;
        logic          out_rdy;
        logic [N-1:0]  exp_rdy;
        logic          exp_ovld;
        logic [W-1:0]  exp_oflit;
        logic [N-1:0]  exp_gnt;
        logic          exp_perr;
        logic [15:0]   exp_cnt;
    } vec_t;

    vec_t         tbl[16];
    logic [W-1:0] src_q[N][$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] sgl[N];
    int           checks = 0;
    int           errors = 0;

    logic [N-1:0] s_rdy, s_gnt;
    logic         s_ovld, s_perr;
    logic [W-1:0] s_oflit;
    logic [15:0]  s_cnt;

    function automatic logic [W-1:0] mk(input flit_type_e t, input int id, input int seq);
        return {t, 14'h0, 8'(id), 8'(seq)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver: present queue heads, sample outputs, score transfers, pop accepted flits.
    task automatic run_cycle();
        logic [N-1:0] acc;
        logic [W-1:0] e;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                req_vld_i[i]          = 1'b1;
                req_flit_i[i*W +: W]  = src_q[i][0];
            end else begin
                req_vld_i[i]          = 1'b0;
                req_flit_i[i*W +: W]  = '0;
            end
        end
        #1;
        s_rdy   = req_rdy_o;
        s_gnt   = grant_o;
        s_ovld  = out_vld_o;
        s_oflit = out_flit_o;
        s_perr  = proto_err_o;
        s_cnt   = pkt_cnt_o;
        acc     = req_vld_i & req_rdy_o;
        if (out_vld_o && out_rdy_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: got flit %0h expected no flit", out_flit_o);
            end else begin
                e = exp_q.pop_front();
                chk("sb_flit", out_flit_o, e);
            end
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (acc[i]) void'(src_q[i].pop_front());
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            run_cycle();
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_vld_i = '0;
        out_rdy_i = 1'b1;
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) sgl[i] = mk(FLIT_SINGLE, i, 0);

        // Round-robin table: every requester always offers one SINGLE.
        for (int r = 0; r <= 8; r++) begin
            tbl[r] = '{4'hF, 1'b1, 4'(1 << (r % 4)), (r > 0), sgl[(r + 3) % 4], 4'h0, 1'b0, 16'(r)};
        end
        tbl[9]  = '{4'h0, 1'b1, 4'h0, 1'b1, sgl[0], 4'h0, 1'b0, 16'd9};
        tbl[10] = '{4'h0, 1'b1, 4'h0, 1'b0, sgl[0], 4'h0, 1'b0, 16'd9};
        tbl[11] = '{4'h4, 1'b1, 4'h4, 1'b0, sgl[0], 4'h0, 1'b0, 16'd9};
        tbl[12] = '{4'h4, 1'b0, 4'h0, 1'b1, sgl[2], 4'h0, 1'b0, 16'd10};
        tbl[13] = '{4'h0, 1'b0, 4'h0, 1'b1, sgl[2], 4'h0, 1'b0, 16'd10};
        tbl[14] = '{4'h0, 1'b1, 4'h0, 1'b1, sgl[2], 4'h0, 1'b0, 16'd10};
        tbl[15] = '{4'h0, 1'b1, 4'h0, 1'b0, sgl[2], 4'h0, 1'b0, 16'd10};

        // Reset with every requester valid
        rst       = 1'b1;
        out_rdy_i = 1'b1;
        req_vld_i = '1;
        for (int i = 0; i < N; i++) req_flit_i[i*W +: W] = sgl[i];
        @(negedge clk);
        #1;
        chk("rst_rdy", req_rdy_o, 0);
        chk("rst_ovld", out_vld_o, 0);
        chk("rst_cnt", pkt_cnt_o, 0);
        chk("rst_gnt", grant_o, 0);
        chk("rst_perr", proto_err_o, 0);
        @(negedge clk);
        #1;
        chk("rst_rdy_edge", req_rdy_o, 0);
        chk("rst_ovld_edge", out_vld_o, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < 16; r++) begin
            req_vld_i = tbl[r].vld;
            out_rdy_i = tbl[r].out_rdy;
            #1;
            chk($sformatf("tbl%0d_rdy", r), req_rdy_o, tbl[r].exp_rdy);
            chk($sformatf("tbl%0d_ovld", r), out_vld_o, tbl[r].exp_ovld);
            if (tbl[r].exp_ovld) chk($sformatf("tbl%0d_flit", r), out_flit_o, tbl[r].exp_oflit);
            chk($sformatf("tbl%0d_gnt", r), grant_o, tbl[r].exp_gnt);
            chk($sformatf("tbl%0d_perr", r), proto_err_o, tbl[r].exp_perr);
            chk($sformatf("tbl%0d_cnt", r), pkt_cnt_o, tbl[r].exp_cnt);
            @(posedge clk);
            @(negedge clk);
        end

        // Packet lock: req0 packet, req1 waiting with a SINGLE
        do_reset();
        src_q[0] = '{mk(FLIT_HEAD, 0, 1), mk(FLIT_BODY, 0, 2), mk(FLIT_BODY, 0, 3), mk(FLIT_TAIL, 0, 4)};
        src_q[1] = '{mk(FLIT_SINGLE, 1, 1)};
        exp_q    = '{mk(FLIT_HEAD, 0, 1), mk(FLIT_BODY, 0, 2), mk(FLIT_BODY, 0, 3), mk(FLIT_TAIL, 0, 4),
                     mk(FLIT_SINGLE, 1, 1)};
        run_cycle();
        chk("lock_rdy_head", s_rdy, 4'b0001);
        for (int c = 1; c <= 3; c++) begin
            run_cycle();
            chk($sformatf("lock_gnt_c%0d", c), s_gnt, 4'b0001);
            chk($sformatf("lock_rdy_c%0d", c), s_rdy, 4'b0001);
            chk($sformatf("lock_ovld_c%0d", c), s_ovld, 1);
        end
        run_cycle();
        chk("lock_next_rdy", s_rdy, 4'b0010);
        chk("lock_gnt_drop", s_gnt, 4'b0000);
        chk("lock_ovld_c4", s_ovld, 1);
        run_cycle();
        chk("lock_ovld_c5", s_ovld, 1);
        drain();
        chk("lock_cnt", pkt_cnt_o, 2);

        // Backpressure mid-packet
        do_reset();
        src_q[3] = '{mk(FLIT_HEAD, 3, 1), mk(FLIT_BODY, 3, 2), mk(FLIT_BODY, 3, 3), mk(FLIT_TAIL, 3, 4)};
        exp_q    = '{mk(FLIT_HEAD, 3, 1), mk(FLIT_BODY, 3, 2), mk(FLIT_BODY, 3, 3), mk(FLIT_TAIL, 3, 4)};
        run_cycle();
        run_cycle();
        out_rdy_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            run_cycle();
            chk($sformatf("stall%0d_rdy", c), s_rdy, 0);
            chk($sformatf("stall%0d_ovld", c), s_ovld, 1);
            chk($sformatf("stall%0d_flit", c), s_oflit, mk(FLIT_BODY, 3, 2));
            chk($sformatf("stall%0d_gnt", c), s_gnt, 4'b1000);
        end
        out_rdy_i = 1'b1;
        drain();
        chk("bp_cnt", pkt_cnt_o, 1);
        chk("bp_gnt_idle", grant_o, 0);

        // TAIL arriving in IDLE
        do_reset();
        src_q[1] = '{mk(FLIT_TAIL, 1, 7)};
        exp_q    = '{mk(FLIT_TAIL, 1, 7)};
        run_cycle();
        chk("perr_before", s_perr, 0);
        run_cycle();
        chk("perr_set", s_perr, 1);
        chk("perr_cnt", s_cnt, 1);
        chk("perr_fwd_ovld", s_ovld, 1);
        src_q[2] = '{mk(FLIT_SINGLE, 2, 8)};
        exp_q.push_back(mk(FLIT_SINGLE, 2, 8));
        drain();
        repeat (3) run_cycle();
        chk("perr_sticky", proto_err_o, 1);
        chk("perr_cnt2", pkt_cnt_o, 2);

        // Reset after a HEAD is accepted
        do_reset();
        src_q[0] = '{mk(FLIT_HEAD, 0, 9)};
        run_cycle();
        chk("mid_gnt_before", grant_o, 4'b0001);
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", grant_o, 0);
        chk("mid_rst_ovld", out_vld_o, 0);
        chk("mid_rst_rdy", req_rdy_o, 0);
        @(negedge clk);
        rst = 1'b0;
        src_q[2] = '{mk(FLIT_HEAD, 2, 1), mk(FLIT_TAIL, 2, 2)};
        exp_q    = '{mk(FLIT_HEAD, 2, 1), mk(FLIT_TAIL, 2, 2)};
        run_cycle();
        chk("mid_req2_rdy", s_rdy, 4'b0100);
        run_cycle();
        chk("mid_req2_gnt", s_gnt, 4'b0100);
        drain();
        chk("mid_cnt", pkt_cnt_o, 1);
        chk("mid_perr", proto_err_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
